move_key_pulser: RTL

- Front end of the player horizontal-move path: turns raw, bouncy left/right push-buttons into clean single-cycle step strobes.
- Strobes drive the left/right shift inputs of the player position/facing block.
- Adds synchroniser, debounce, left/right arbitration, pause gating and hold-to-auto-repeat.
- Also keeps a registered facing flag that matches the strobe stream.

---
 rtl/move_key_pulser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/move_key_pulser.sv
// Left/right push-button front end: 2-flop sync, per-button debounce, arbitration,
// pause gating and single-cycle step strobes. `MOVE_AUTOREPEAT_EN adds hold-to-repeat.
module move_key_pulser #(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_RATE     = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       pause,
  output logic       left_shift,
  output logic       right_shift,
  output logic       face_rl,
  output logic [1:0] key_state
);

  // Load values are clamped to the counter range so oversize settings saturate.
  localparam longint unsigned CNT_TOP = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] DEB_LIM =
    CNT_W'((64'(DEBOUNCE_CYCLES) > CNT_TOP) ? CNT_TOP : 64'(DEBOUNCE_CYCLES));

  if (REPEAT_RATE < 2 || REPEAT_DELAY < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("move_key_pulser: illegal debounce/repeat parameters");
  end

  logic [1:0]            sync1, sync2, deb;
  logic [1:0][CNT_W-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= {btn_right, btn_left};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= DEB_LIM) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign key_state = deb;

  logic left_held, right_held, hold_ok;
  logic fire, fire_dir;
  logic dir_r, dir_nxt;

  assign left_held  = deb[0] & ~deb[1];
  assign right_held = deb[1] & ~deb[0];
  assign hold_ok    = ~pause & (dir_r ? right_held : left_held);

`ifdef MOVE_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] DELAY_LD =
    CNT_W'((64'(REPEAT_DELAY) > CNT_TOP) ? CNT_TOP : 64'(REPEAT_DELAY));
  localparam logic [CNT_W-1:0] RATE_LD =
    CNT_W'((64'(REPEAT_RATE) > CNT_TOP) ? CNT_TOP : 64'(REPEAT_RATE));

  logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
  logic             rpt_due;

  assign rpt_due = (rpt_cnt <= CNT_W'(1));
`else
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
`endif

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dir_r       <= 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
      rpt_cnt     <= '0;
`endif
      left_shift  <= 1'b0;
      right_shift <= 1'b0;
      face_rl     <= 1'b1;
    end else begin
      state       <= state_nxt;
      dir_r       <= dir_nxt;
`ifdef MOVE_AUTOREPEAT_EN
      rpt_cnt     <= rpt_nxt;
`endif
      left_shift  <= fire & ~fire_dir;
      right_shift <= fire & fire_dir;
      if (fire) face_rl <= fire_dir;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_r;
`ifdef MOVE_AUTOREPEAT_EN
    rpt_nxt   = rpt_cnt;
    case (state)
      IDLE: begin
        rpt_nxt = '0;
        if (fire) begin
          state_nxt = DELAY;
          dir_nxt   = right_held;
          rpt_nxt   = DELAY_LD;
        end
      end
      DELAY, REPEAT: begin
        if (!hold_ok) begin
          state_nxt = IDLE;
          rpt_nxt   = '0;
        end else if (rpt_due) begin
          state_nxt = REPEAT;
          rpt_nxt   = RATE_LD;
        end else begin
          rpt_nxt = rpt_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        rpt_nxt   = '0;
      end
    endcase
`else
    case (state)
      IDLE: begin
        if (fire) begin
          state_nxt = HOLD;
          dir_nxt   = right_held;
        end
      end
      HOLD:    if (!hold_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`endif
  end

  always_comb begin
    fire     = 1'b0;
    fire_dir = dir_r;
    case (state)
      IDLE: begin
        fire     = (left_held | right_held) & ~pause;
        fire_dir = right_held;
      end
`ifdef MOVE_AUTOREPEAT_EN
      DELAY, REPEAT: fire = hold_ok & rpt_due;
`endif
      default: fire = 1'b0;
    endcase
  end

endmodule
